fp_add_cmp_cvt: RTL and testbench
=================================

# fp_add_cmp_cvt

Single-precision (IEEE-754 binary32) arithmetic slice of the FPU: a pipelined adder/subtractor, a single-cycle-registered comparator and a pipelined signed-int32-to-float converter. All three share the operand inputs and run every cycle; the FPU ALU selects the result and waits a fixed cycle count per operation.

## Interface
- No parameters.
- clk  in  1  clock; all registers update on the rising edge.
- areset_n  in  1  asynchronous active-low reset; clears every pipeline register.
- a  in  32  operand A: binary32 for add/sub/compare, two's-complement int32 for conversion.
- b  in  32  operand B: binary32.
- opSel  in  1  1 = a+b, 0 = a−b; sampled with a/b.
- q  out  32  add/sub result.
- aeb  out  1  a == b.
- alb  out  1  a < b.
- aleb  out  1  a <= b.
- q_cvt  out  32  float(a) for signed int32 a.

## Operation
- Rounding: round-to-nearest, ties-to-even, for both add/sub and conversion.
- Subnormals: subnormal inputs are treated as signed zero; subnormal results are flushed to signed zero.
- Add/sub: subtraction is a+(−b).
  - Align exponents with guard/round/sticky bits, add or subtract magnitudes, then normalise (leading-zero count) and round.
  - A rounding carry-out increments the exponent.
  - Exponent ≥255 after rounding gives ±inf (0x7F800000/0xFF800000).
  - Exact zero from opposite-signed operands is +0. (−0)+(−0) = −0.
  - Any NaN operand, or inf−inf, gives canonical NaN 0x7FC00000.
  - inf ± finite gives that inf.
- Compare:
  - Any NaN operand: aeb = alb = aleb = 0.
  - +0 and −0 are equal.
  - Otherwise use standard ordered comparison; aleb = alb | aeb.
- Convert:
  - a = 0 gives 0x00000000.
  - Otherwise: sign = a[31]; magnitude = |a| (0x80000000 gives magnitude 2^31).
  - Normalise via leading-zero count; exponent = 127 + msb position.
  - Round the 32-bit magnitude to 24 bits; a carry-out bumps the exponent.
  - Results are always exact or finite.
- No handshake or valid signals. The pipelines accept new operands every cycle, fully pipelined with throughput 1 per unit.

## Timing
- Reset: while areset_n = 0, all registers are held at 0. q = 0, q_cvt = 0, aeb = alb = aleb = 0, immediately and asynchronously.
- Deassertion is synchronised externally; the first capture happens at the first rising edge with areset_n = 1.
- Latency, counted in rising edges after operands are stable before edge 0:
  - Add/sub: 3. Result is valid after the 3rd edge.
  - Compare: 1. Flags are registered on the 1st edge.
  - Convert: 2.
  - All latencies fit the FPALU waits (6/3/4 cycles).
- Back-to-back: operands changed every cycle produce results in the same order, one per cycle, with no bubbles.
- Reset mid-operation: all in-flight results are discarded and outputs go to 0 at once. After release, outputs reflect only operands captured after release. Stages not yet refilled output 0.
- Operands must be held stable for the full latency only if the consumer samples after the latency. The FPALU holds them, so the result stays stable after the latency while inputs are unchanged.

## Test plan
- Add/sub basics:
  - a=0x3F800000, b=0x40000000, opSel=1: q=0x40400000 after 3 edges.
  - opSel=0, a=b=0x3F800000: q=0x00000000.
  - Back-to-back over 3 cycles: results appear in order.
- Add/sub specials:
  - 0x7F800000 + 0xFF800000: q=0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF: q=0x7F800000.
  - 0x3F800000 + 0x33800000 (1 + 2^−24, tie): q=0x3F800000.
- Compare:
  - 1.0 vs 2.0: aeb=0, alb=1, aleb=1, after 1 edge.
  - 0x80000000 vs 0x00000000: aeb=1, alb=0, aleb=1.
  - a=0x7FC00000: all flags 0.
- Convert:
  - 0xFFFFFFFF gives 0xBF800000.
  - 0x80000000 gives 0xCF000000.
  - 16777217 gives 0x4B800000.
  - 16777219 gives 0x4B800002.
  - 0 gives 0x00000000.
  - All after 2 edges.
- Reset:
  - Drop areset_n mid-stream with results in flight: all outputs 0 before the next edge.
  - Release: outputs stay 0 until the new operands' latencies elapse, then show correct values.
- Random: 10k random operand pairs versus a software IEEE model with round-to-nearest-even and flush-to-zero. Require bit-exact q, q_cvt and flags.

Source files
------------

// File: rtl/fp_add_cmp_cvt.sv
// Binary32 add/sub (3 stages), compare (1 stage) and int32-to-float convert (2 stages).
// Subnormal inputs read as signed zero, subnormal results flush to signed zero, rounding is RNE.
module fp_add_cmp_cvt (
    input  logic        clk,
    input  logic        areset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        opSel,
    output logic [31:0] q,
    output logic        aeb,
    output logic        alb,
    output logic        aleb,
    output logic [31:0] q_cvt
);

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    function automatic logic [5:0] lzc32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

    logic        sb_eff;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;

    assign sb_eff = b[31] ^ ~opSel;
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign ma     = a_zero ? 24'd0 : {1'b1, a[22:0]};
    assign mb     = b_zero ? 24'd0 : {1'b1, b[22:0]};
    assign a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    assign a_big  = {ea, ma[22:0]} >= {eb, mb[22:0]};

    // Stage 1: order by magnitude so the subtract never goes negative, align with G/R/S
    logic        s1_sign_d, s1_sign_q, s1_sub_d, s1_sub_q, s1_spec_d, s1_spec_q;
    logic [7:0]  s1_exp_d, s1_exp_q;
    logic [26:0] s1_big_d, s1_big_q, s1_small_d, s1_small_q;
    logic [31:0] s1_val_d, s1_val_q;
    logic [7:0]  shift_amt;
    logic [26:0] small_ext;

    always_comb begin
        s1_spec_d = 1'b1;
        s1_val_d  = 32'h7FC0_0000;
        s1_sub_d  = a[31] ^ sb_eff;
        s1_sign_d = a_big ? a[31] : sb_eff;
        s1_exp_d  = a_big ? ea : eb;
        s1_big_d  = {(a_big ? ma : mb), 3'b000};
        small_ext = {(a_big ? mb : ma), 3'b000};
        shift_amt = a_big ? (ea - eb) : (eb - ea);
        if (shift_amt >= 8'd27) begin
            s1_small_d = (small_ext != 27'd0) ? 27'd1 : 27'd0;
        end else begin
            s1_small_d    = small_ext >> shift_amt;
            s1_small_d[0] = s1_small_d[0] | (|(small_ext & ((27'd1 << shift_amt) - 27'd1)));
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb_eff))) begin
            s1_val_d = 32'h7FC0_0000;
        end else if (a_inf) begin
            s1_val_d = {a[31], 8'hFF, 23'd0};
        end else if (b_inf) begin
            s1_val_d = {sb_eff, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            s1_val_d = {a[31] & sb_eff, 31'd0};
        end else begin
            s1_spec_d = 1'b0;
        end
    end

    // Stage 2: magnitude add/sub and normalisation; a carry-out folds its LSB into sticky
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic              s2_sign_d, s2_sign_q, s2_zero_d, s2_zero_q, s2_spec_d, s2_spec_q;
    logic signed [9:0] s2_exp_d, s2_exp_q;
    logic [26:0]       s2_man_d, s2_man_q;
    logic [31:0]       s2_val_d, s2_val_q;

    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                       : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
        lz        = lzc27(sum[26:0]);
        s2_sign_d = s1_sign_q;
        s2_spec_d = s1_spec_q;
        s2_val_d  = s1_val_q;
        s2_zero_d = (sum == 28'd0);
        if (sum[27]) begin
            s2_man_d = {sum[27:2], sum[1] | sum[0]};
            s2_exp_d = $signed({2'b00, s1_exp_q}) + 10'sd1;
        end else begin
            s2_man_d = sum[26:0] << lz;
            s2_exp_d = $signed({2'b00, s1_exp_q}) - $signed({5'd0, lz});
        end
    end

    // Stage 3: round to nearest even, then overflow to inf or flush to signed zero
    logic              round_up;
    logic [24:0]       man_r;
    logic signed [9:0] exp_r;
    logic [31:0]       q_d, q_q;

    always_comb begin
        round_up = s2_man_q[2] & (s2_man_q[3] | s2_man_q[1] | s2_man_q[0]);
        man_r    = {1'b0, s2_man_q[26:3]} + {24'd0, round_up};
        exp_r    = s2_exp_q + (man_r[24] ? 10'sd1 : 10'sd0);
        if (s2_spec_q) begin
            q_d = s2_val_q;
        end else if (s2_zero_q) begin
            q_d = 32'd0;
        end else if (exp_r <= 10'sd0) begin
            q_d = {s2_sign_q, 31'd0};
        end else if (exp_r >= 10'sd255) begin
            q_d = {s2_sign_q, 8'hFF, 23'd0};
        end else begin
            q_d = {s2_sign_q, exp_r[7:0], (man_r[24] ? 23'd0 : man_r[22:0])};
        end
    end

    logic [31:0] fa, fb;
    logic        aeb_d, aeb_q, alb_d, alb_q, aleb_d, aleb_q;

    assign fa = a_zero ? {a[31], 31'd0} : a;
    assign fb = b_zero ? {b[31], 31'd0} : b;

    always_comb begin
        aeb_d = 1'b0;
        alb_d = 1'b0;
        if (!(a_nan || b_nan)) begin
            if (a_zero && b_zero) begin
                aeb_d = 1'b1;
            end else begin
                aeb_d = (fa == fb);
                if (fa[31] != fb[31]) alb_d = fa[31];
                else if (fa[31])      alb_d = fa[30:0] > fb[30:0];
                else                  alb_d = fa[30:0] < fb[30:0];
            end
        end
        aleb_d = alb_d | aeb_d;
    end

    // Convert: normalise the magnitude in stage 1, round 32 bits down to 24 in stage 2
    logic [31:0] cvt_mag;
    logic [5:0]  cvt_lz;
    logic        c1_sign_d, c1_sign_q, c1_zero_d, c1_zero_q;
    logic [7:0]  c1_exp_d, c1_exp_q;
    logic [31:0] c1_man_d, c1_man_q;
    logic        cvt_up;
    logic [24:0] cvt_r;
    logic [31:0] q_cvt_d, q_cvt_q;

    always_comb begin
        cvt_mag   = a[31] ? (~a + 32'd1) : a;
        cvt_lz    = lzc32(cvt_mag);
        c1_sign_d = a[31];
        c1_zero_d = (a == 32'd0);
        c1_man_d  = cvt_mag << cvt_lz;
        c1_exp_d  = 8'd158 - {2'b00, cvt_lz};
    end

    always_comb begin
        cvt_up = c1_man_q[7] & (c1_man_q[8] | (|c1_man_q[6:0]));
        cvt_r  = {1'b0, c1_man_q[31:8]} + {24'd0, cvt_up};
        if (c1_zero_q) begin
            q_cvt_d = 32'd0;
        end else begin
            q_cvt_d = {c1_sign_q, c1_exp_q + {7'd0, cvt_r[24]}, (cvt_r[24] ? 23'd0 : cvt_r[22:0])};
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s1_sign_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_spec_q  <= 1'b0;
            s1_exp_q   <= 8'd0;
            s1_big_q   <= 27'd0;
            s1_small_q <= 27'd0;
            s1_val_q   <= 32'd0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_spec_q  <= 1'b0;
            s2_exp_q   <= 10'sd0;
            s2_man_q   <= 27'd0;
            s2_val_q   <= 32'd0;
            q_q        <= 32'd0;
            aeb_q      <= 1'b0;
            alb_q      <= 1'b0;
            aleb_q     <= 1'b0;
            c1_sign_q  <= 1'b0;
            c1_zero_q  <= 1'b0;
            c1_exp_q   <= 8'd0;
            c1_man_q   <= 32'd0;
            q_cvt_q    <= 32'd0;
        end else begin
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_spec_q  <= s1_spec_d;
            s1_exp_q   <= s1_exp_d;
            s1_big_q   <= s1_big_d;
            s1_small_q <= s1_small_d;
            s1_val_q   <= s1_val_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_spec_q  <= s2_spec_d;
            s2_exp_q   <= s2_exp_d;
            s2_man_q   <= s2_man_d;
            s2_val_q   <= s2_val_d;
            q_q        <= q_d;
            aeb_q      <= aeb_d;
            alb_q      <= alb_d;
            aleb_q     <= aleb_d;
            c1_sign_q  <= c1_sign_d;
            c1_zero_q  <= c1_zero_d;
            c1_exp_q   <= c1_exp_d;
            c1_man_q   <= c1_man_d;
            q_cvt_q    <= q_cvt_d;
        end
    end

    assign q     = q_q;
    assign aeb   = aeb_q;
    assign alb   = alb_q;
    assign aleb  = aleb_q;
    assign q_cvt = q_cvt_q;

endmodule

// File: tb/tb_fp_add_cmp_cvt.sv
// Self-checking bench for fp_add_cmp_cvt: directed cases plus a random stream
// checked against a double-precision reference with RNE and flush-to-zero.
module tb_fp_add_cmp_cvt;

    localparam int N_RAND = 10000;

    logic        clk = 1'b0;
    logic        areset_n;
    logic [31:0] a, b;
    logic        opSel;
    logic [31:0] q, q_cvt;
    logic        aeb, alb, aleb;

    int checks = 0;
    int errors = 0;

    logic [31:0] rq [N_RAND];
    logic [2:0]  rc [N_RAND];
    logic [31:0] rv [N_RAND];

    fp_add_cmp_cvt dut (
        .clk(clk), .areset_n(areset_n), .a(a), .b(b), .opSel(opSel),
        .q(q), .aeb(aeb), .alb(alb), .aleb(aleb), .q_cvt(q_cvt)
    );

    always #5 clk = ~clk;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    endfunction

    // Exact widening to double, with subnormals read as signed zero
    function automatic real fp_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0)       d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, 52'd0};
        else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Narrow a double to binary32 with RNE, overflow to inf, flush tiny to signed zero
    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] keep;
        logic [28:0] rem;
        int e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e    = int'(d[62:52]) - 1023 + 127;
        m    = {1'b1, d[51:0]};
        keep = {1'b0, m[52:29]};
        rem  = m[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin
            keep = keep >> 1;
            e = e + 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic op);
        logic [31:0] yy;
        yy = op ? y : (y ^ 32'h8000_0000);
        if (is_nan(x) || is_nan(yy)) return 32'h7FC0_0000;
        if (is_inf(x) && is_inf(yy) && (x[31] != yy[31])) return 32'h7FC0_0000;
        if (is_inf(x))  return {x[31], 31'h7F80_0000};
        if (is_inf(yy)) return {yy[31], 31'h7F80_0000};
        return real_to_fp(fp_to_real(x) + fp_to_real(yy));
    endfunction

    function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y);
        real rx, ry;
        if (is_nan(x) || is_nan(y)) return 3'b000;
        rx = fp_to_real(x);
        ry = fp_to_real(y);
        return {rx == ry, rx < ry, rx <= ry};
    endfunction

    function automatic logic [31:0] ref_cvt(input logic [31:0] x);
        real r;
        if (x == 32'd0) return 32'd0;
        r = real'($signed(x));
        return real_to_fp(r);
    endfunction

    function automatic logic [31:0] rand_fp(input int near);
        int e;
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel == 0) begin
            case ($urandom_range(0, 7))
                0: return 32'h0000_0000;
                1: return 32'h8000_0000;
                2: return 32'h7F80_0000;
                3: return 32'hFF80_0000;
                4: return 32'h7FC0_0000;
                5: return 32'h7F80_0001;
                6: return 32'h0000_0001;
                default: return 32'h7F7F_FFFF;
            endcase
        end
        if (sel < 5) return $urandom;
        e = near + int'($urandom_range(0, 8)) - 4;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        return {1'($urandom_range(0, 1)), e[7:0], 23'($urandom)};
    endfunction

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb_v, input logic top);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        opSel = top;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        a = 32'h3F80_0000; b = 32'h4000_0000; opSel = 1'b1;
        #1;
        checks++;
        if ({q, q_cvt, aeb, alb, aleb} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_initial: q=%h q_cvt=%h flags=%b%b%b expected all zero", q, q_cvt, aeb, alb, aleb);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({q, q_cvt, aeb, alb, aleb} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_held: q=%h q_cvt=%h flags=%b%b%b expected all zero", q, q_cvt, aeb, alb, aleb);
        end
        areset_n = 1'b1;
    endtask

    task automatic test_add_basic();
        drive(32'h3F80_0000, 32'h4000_0000, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (q !== 32'h4040_0000) begin
            errors++;
            $display("[TB] FAIL add_1_plus_2: q=%h expected 40400000", q);
        end
        drive(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (q !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL sub_1_minus_1: q=%h expected 00000000", q);
        end
    endtask

    task automatic test_add_special();
        logic [31:0] ta [8] = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h8000_0000,
                                32'h7F80_0000, 32'h0000_0001, 32'h0080_0001, 32'h0080_0000};
        logic [31:0] tb_v [8] = '{32'hFF80_0000, 32'h7F7F_FFFF, 32'h3380_0000, 32'h8000_0000,
                                32'h3F80_0000, 32'h8000_0000, 32'h0080_0000, 32'h0080_0001};
        logic        top [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_q [8] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h8000_0000,
                                   32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
        for (int i = 0; i < 8; i++) begin
            drive(ta[i], tb_v[i], top[i]);
            repeat (3) @(negedge clk);
            checks++;
            if (q !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL add_special[%0d]: q=%h expected %h", i, q, exp_q[i]);
            end
        end
    endtask

    task automatic test_compare();
        logic [31:0] ta [4] = '{32'h3F80_0000, 32'h8000_0000, 32'h7FC0_0000, 32'hC000_0000};
        logic [31:0] tb_v [4] = '{32'h4000_0000, 32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000};
        logic [2:0]  exp_f [4] = '{3'b011, 3'b101, 3'b000, 3'b011};
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb_v[i], 1'b1);
            @(negedge clk);
            checks++;
            if ({aeb, alb, aleb} !== exp_f[i]) begin
                errors++;
                $display("[TB] FAIL compare[%0d]: aeb/alb/aleb=%b expected %b", i, {aeb, alb, aleb}, exp_f[i]);
            end
        end
    endtask

    task automatic test_convert();
        logic [31:0] ta [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd16777217, 32'd16777219, 32'd0};
        logic [31:0] exp_c [5] = '{32'hBF80_0000, 32'hCF00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h0000_0000};
        for (int i = 0; i < 5; i++) begin
            drive(ta[i], 32'h0, 1'b1);
            repeat (2) @(negedge clk);
            checks++;
            if (q_cvt !== exp_c[i]) begin
                errors++;
                $display("[TB] FAIL convert[%0d]: q_cvt=%h expected %h", i, q_cvt, exp_c[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [3] = '{32'h4040_0000, 32'h4080_0000, 32'h4000_0000};
        drive(32'h3F80_0000, 32'h4000_0000, 1'b1);
        drive(32'h4000_0000, 32'h4000_0000, 1'b1);
        drive(32'h4040_0000, 32'h3F80_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (q !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: q=%h expected %h", i, q, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [2:0] exp_f;
        drive(32'h4000_0000, 32'h3F80_0000, 1'b1);
        drive(32'h4040_0000, 32'h3F80_0000, 1'b0);
        @(posedge clk);
        #2;
        areset_n = 1'b0;
        #1;
        checks++;
        if ({q, q_cvt, aeb, alb, aleb} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_async: q=%h q_cvt=%h flags=%b%b%b expected all zero", q, q_cvt, aeb, alb, aleb);
        end
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        a = 32'h3F80_0000; b = 32'h4080_0000; opSel = 1'b1;
        exp_f = ref_cmp(a, b);
        @(negedge clk);
        checks++;
        if ({q, q_cvt, aeb, alb, aleb} !== {64'd0, exp_f}) begin
            errors++;
            $display("[TB] FAIL reset_release_1: q=%h q_cvt=%h flags=%b%b%b expected 0/0/%b", q, q_cvt, aeb, alb, aleb, exp_f);
        end
        @(negedge clk);
        checks++;
        if ({q, q_cvt} !== {32'd0, ref_cvt(32'h3F80_0000)}) begin
            errors++;
            $display("[TB] FAIL reset_release_2: q=%h q_cvt=%h expected 0/%h", q, q_cvt, ref_cvt(32'h3F80_0000));
        end
        @(negedge clk);
        checks++;
        if (q !== 32'h40A0_0000) begin
            errors++;
            $display("[TB] FAIL reset_release_3: q=%h expected 40a00000", q);
        end
    endtask

    task automatic test_random();
        logic [31:0] ta, tb_v;
        logic        top;
        int          near;
        for (int m = 0; m < N_RAND + 3; m++) begin
            @(negedge clk);
            if (m >= 1 && m <= N_RAND) begin
                checks++;
                if ({aeb, alb, aleb} !== rc[m-1]) begin
                    errors++;
                    $display("[TB] FAIL rand_cmp[%0d]: flags=%b expected %b", m-1, {aeb, alb, aleb}, rc[m-1]);
                end
            end
            if (m >= 2 && m <= N_RAND + 1) begin
                checks++;
                if (q_cvt !== rv[m-2]) begin
                    errors++;
                    $display("[TB] FAIL rand_cvt[%0d]: q_cvt=%h expected %h", m-2, q_cvt, rv[m-2]);
                end
            end
            if (m >= 3) begin
                checks++;
                if (q !== rq[m-3]) begin
                    errors++;
                    $display("[TB] FAIL rand_add[%0d]: q=%h expected %h", m-3, q, rq[m-3]);
                end
            end
            if (m < N_RAND) begin
                near = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 254));
                ta = rand_fp(near);
                if ($urandom_range(0, 5) == 0) begin
                    ta = $urandom_range(0, 100000);
                    if ($urandom_range(0, 1) == 1) ta = ~ta + 32'd1;
                end
                case ($urandom_range(0, 7))
                    0: tb_v = ta;
                    1: tb_v = ta ^ 32'h8000_0000;
                    2: tb_v = ta ^ {29'd0, 3'($urandom_range(0, 7))};
                    3: tb_v = $urandom;
                    default: tb_v = rand_fp(int'(ta[30:23]));
                endcase
                top   = 1'($urandom_range(0, 1));
                rq[m] = ref_add(ta, tb_v, top);
                rc[m] = ref_cmp(ta, tb_v);
                rv[m] = ref_cvt(ta);
                a     = ta;
                b     = tb_v;
                opSel = top;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_special();
        test_compare();
        test_convert();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
